// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a length-prefixed byte stream into big-endian 32-bit words
// and writes them to IMem from address 0. Optional trailing checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [16:0]     MaxWords = 17'(1) << ADDR_W;
  localparam logic [ADDR_W:0] CntOne   = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    StIdle,
    StHeader,
    StCollect,
    StWrite,
    StCheck,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [ADDR_W:0]     n_q, n_d;
  logic [1:0]          idx_q, idx_d;
  logic [7:0]          hdr_hi_q, hdr_hi_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]          sum_q, sum_d;
`endif

  logic        xfer;
  logic [15:0] hdr_n;

  // start wins over a simultaneous byte, so the byte must not be acknowledged.
  assign byte_ready = ((state_q == StHeader) || (state_q == StCollect) ||
                       (state_q == StCheck)) && !start;
  assign xfer       = byte_valid && byte_ready;
  assign hdr_n      = {hdr_hi_q, byte_data};

  always_comb begin
    state_d  = state_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    done_d   = done_q;
    error_d  = error_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    idx_d    = idx_q;
    hdr_hi_d = hdr_hi_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d    = sum_q;
`endif

    if (start) begin
      state_d  = StHeader;
      waddr_d  = '0;
      done_d   = 1'b0;
      error_d  = 1'b0;
      cnt_d    = '0;
      idx_d    = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_d    = '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: ;

        StHeader: begin
          if (xfer) begin
            if (idx_q == 2'd0) begin
              hdr_hi_d = byte_data;
              idx_d    = 2'd1;
            end else begin
              idx_d = 2'd0;
              if ({1'b0, hdr_n} > MaxWords) begin
                error_d = 1'b1;
                done_d  = 1'b1;
                state_d = StDone;
              end else if (hdr_n == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_d = StCheck;
`else
                done_d  = 1'b1;
                state_d = StDone;
`endif
              end else begin
                n_d     = hdr_n[ADDR_W:0];
                state_d = StCollect;
              end
            end
          end
        end

        StCollect: begin
          if (xfer) begin
            wdata_d = {wdata_q[23:0], byte_data};
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_d   = sum_q + byte_data;
`endif
            if (idx_q == 2'd3) begin
              idx_d   = 2'd0;
              we_d    = 1'b1;
              state_d = StWrite;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end
        end

        StWrite: begin
          waddr_d = waddr_q + ADDR_W'(1);
          cnt_d   = cnt_q + CntOne;
          if (cnt_q + CntOne == n_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = StCheck;
`else
            done_d  = 1'b1;
            state_d = StDone;
`endif
          end else begin
            state_d = StCollect;
          end
        end

        StCheck: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (xfer) begin
            error_d = (byte_data != sum_q);
            done_d  = 1'b1;
            state_d = StDone;
          end
`else
          state_d = StIdle;
`endif
        end

        StDone: ;

        default: state_d = StIdle;
      endcase
    end

    busy_d = (state_d != StIdle) && (state_d != StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      cnt_q    <= '0;
      n_q      <= '0;
      idx_q    <= '0;
      hdr_hi_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      idx_q    <= idx_d;
      hdr_hi_q <= hdr_hi_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q    <= sum_d;
`endif
    end
  end

  assign we         = we_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by the stimulus and
// popped by an independent write monitor.
module tb_imem_loader;
  localparam int unsigned AW = 6;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CkEn = 1'b1;
`else
  localparam bit CkEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic          byte_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   word_count;

  imem_loader #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [AW+31:0] exp_q[$];
  logic [AW+31:0] exp_e;
  logic [31:0]    payload[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Write monitor: every we pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0d data=%08h, expected no write", waddr, wdata);
      end else begin
        exp_e = exp_q.pop_front();
        if ({waddr, wdata} !== exp_e || byte_ready !== 1'b0) begin
          errors++;
          $display("FAIL write: addr=%0d data=%08h ready=%b, expected addr=%0d data=%08h ready=0",
                   waddr, wdata, byte_ready, exp_e[AW+31:32], exp_e[31:0]);
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int guard;
    bit acc;
    guard = 0;
    acc   = 1'b0;
    while (!acc) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 2) == 0) begin
        byte_valid = 1'b0;
      end else begin
        byte_valid = 1'b1;
        byte_data  = b;
        #1 acc = byte_ready;
      end
      guard++;
      if (!acc && guard > 300) begin
        chk("byte_accept_timeout", 64'(guard), 64'(0));
        acc = 1'b1;
      end
    end
    @(posedge clk);
    #1 byte_valid = 1'b0;
  endtask

  task automatic run_session(input logic [15:0] n, input bit gaps, input bit bad_ck,
                             input bit do_start);
    logic [7:0]  sum;
    logic [31:0] w;
    sum = 8'h00;
    if (do_start) pulse_start();
    send_byte(n[15:8], gaps);
    send_byte(n[7:0], gaps);
    for (int i = 0; i < int'(n) && i < payload.size(); i++) begin
      w = payload[i];
      exp_q.push_back({AW'(i), w});
      sum = sum + w[31:24] + w[23:16] + w[15:8] + w[7:0];
      send_byte(w[31:24], gaps);
      send_byte(w[23:16], gaps);
      send_byte(w[15:8], gaps);
      send_byte(w[7:0], gaps);
    end
    if (CkEn && n <= 16'd64) send_byte(bad_ck ? sum + 8'h01 : sum, gaps);
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (done !== 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    #1;
  endtask

  task automatic status(input string name, input logic e_err, input logic [AW:0] e_cnt);
    chk({name, "_done"}, 64'(done), 64'(1));
    chk({name, "_error"}, 64'(error), 64'(e_err));
    chk({name, "_count"}, 64'(word_count), 64'(e_cnt));
    chk({name, "_idle_outputs"}, 64'({byte_ready, busy, we}), 64'(0));
    chk({name, "_sb_empty"}, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic all_zero(input string name);
    chk(name, 64'({byte_ready, we, waddr, wdata, busy, done, error, word_count}), 64'(0));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    all_zero("reset_outputs");
    rst_n = 1'b1;

    // Two-word load
    payload = '{32'h20080005, 32'hAC080004};
    run_session(16'h0002, 1'b0, 1'b0, 1'b1);
    wait_done();
    status("t1", 1'b0, 7'd2);
    chk("t1_waddr", 64'(waddr), 64'(2));
    chk("t1_wdata_held", 64'(wdata), 64'h20080005 ^ 64'h20080005 ^ 64'hAC080004);

    // N overflow: 65 words cannot fit
    payload.delete();
    run_session(16'h0041, 1'b0, 1'b0, 1'b1);
    wait_done();
    status("t2_overflow", 1'b1, 7'd0);

    // Empty load
    run_session(16'h0000, 1'b0, 1'b0, 1'b1);
    wait_done();
    status("t2_empty", 1'b0, 7'd0);

    // Exactly full memory; waddr wraps after the last word
    for (int i = 0; i < 64; i++)
      payload.push_back({8'(i), 8'(~i), 8'hA5, 8'(i * 3)});
    run_session(16'h0040, 1'b0, 1'b0, 1'b1);
    wait_done();
    status("t2_full", 1'b0, 7'd64);
    chk("t2_full_waddr_wrap", 64'(waddr), 64'(0));

    // Same two-word load with random valid gaps
    payload = '{32'h20080005, 32'hAC080004};
    run_session(16'h0002, 1'b1, 1'b0, 1'b1);
    wait_done();
    status("t3_gaps", 1'b0, 7'd2);

    // Abort after 6 payload bytes; a zero byte offered with start must not be consumed
    pulse_start();
    exp_q.push_back({AW'(0), 32'h20080005});
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h08, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'hAC, 1'b0);
    send_byte(8'h08, 1'b0);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = 8'h00;
    start      = 1'b1;
    #1 chk("t4_ready_during_start", 64'(byte_ready), 64'(0));
    @(negedge clk);
    start      = 1'b0;
    byte_valid = 1'b0;
    #1 chk("t4_restart_state", 64'({busy, done, word_count}), 64'({1'b1, 1'b0, 7'd0}));
    payload = '{32'h12345678};
    run_session(16'h0001, 1'b0, 1'b0, 1'b0);
    wait_done();
    status("t4_after_abort", 1'b0, 7'd1);

    // Asynchronous reset mid-word, then a clean reload from address 0
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 all_zero("t5_async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    payload = '{32'hCAFEBABE};
    run_session(16'h0001, 1'b0, 1'b0, 1'b1);
    wait_done();
    status("t5_reload", 1'b0, 7'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    payload = '{32'h20080005, 32'hAC080004};
    run_session(16'h0002, 1'b0, 1'b1, 1'b1);
    wait_done();
    status("t6_bad_checksum", 1'b1, 7'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
